one_hot_decoder: RTL and testbench
==================================

// Module: one_hot_decoder
// PURPOSE
//   Converts a one-hot vector back to its binary index (inverse of one_hot_encoder).
//   Registered, valid/ready streaming stage with a 2-entry skid buffer; flags and
//   counts illegal codes (zero-hot or multi-hot). Used on grant/select buses returning
//   from arbiters and one-hot FSM state taps.
// PARAMETERS
//   INPUT_WIDTH    4                      one-hot vector width, >= 2
//   OUTPUT_WIDTH   $clog2(INPUT_WIDTH)    binary index width
//   ERR_CNT_WIDTH  8                      width of saturating illegal-code counter
// PORTS
//   clk          in   1              clock, all logic on rising edge
//   rst_n        in   1              synchronous, active-low reset
//   in_valid     in   1              one_hot_in is valid
//   in_ready     out  1              decoder can accept (registered)
//   one_hot_in   in   INPUT_WIDTH    one-hot code
//   out_valid    out  1              binary_out/out_err valid
//   out_ready    in   1              downstream accepts
//   binary_out   out  OUTPUT_WIDTH   decoded index
//   out_err      out  1              1 = input was not exactly one-hot
//   err_clear    in   1              synchronous clear of err_count
//   err_count    out  ERR_CNT_WIDTH  saturating count of accepted illegal codes
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): buffer EMPTY; in_ready=1, out_valid=0, binary_out=0,
//   out_err=0, err_count=0. Takes priority over every other input; in-flight data dropped.
// - Accept: in_valid & in_ready at posedge. Emit: out_valid & out_ready at posedge.
// - Decode, combinational on the input side, stored with each entry:
//     exactly one bit set -> index of that bit, err=0
//     multiple bits set   -> index of LOWEST set bit, err=1
//     zero bits set       -> index 0, err=1
// - Buffer FSM (2 entries, FIFO order, head drives outputs):
//     EMPTY: accept -> ONE
//     ONE:   accept & !emit -> FULL; emit & !accept -> EMPTY; both -> ONE
//     FULL:  emit -> ONE (no accept, in_ready=0)
//   in_ready = (state != FULL), registered. out_valid = (state != EMPTY).
// - Latency: accepted input visible on outputs the cycle after acceptance when buffer
//   was EMPTY (or head emitted same cycle). Throughput 1/cycle with out_ready=1.
// - Outputs hold stable while out_valid=1 and out_ready=0.
// - out_ready ignored when out_valid=0; in_valid ignored when in_ready=0.
// - err_count: +1 per accepted input with err=1, saturates at 2^ERR_CNT_WIDTH-1 (no wrap).
//   err_clear=1 -> 0, overriding a same-cycle increment.
// - binary_out/out_err hold last emitted value when buffer empties (not re-zeroed).
// TESTING (INPUT_WIDTH=4 unless stated)
// 1. out_ready=1, feed 0001,0010,0100,1000 back-to-back -> binary_out 0,1,2,3 on
//    consecutive cycles, 1 cycle after each accept, out_err=0, err_count=0.
// 2. feed 0000 then 1010 -> binary_out 0/err=1, then 1/err=1; err_count=2.
// 3. out_ready=0, in_valid=1 with 0100,1000,0001 -> first two accepted, in_ready=0
//    from cycle after 2nd accept; raise out_ready -> outputs 2,3 then 0 in order, none lost.
// 4. ERR_CNT_WIDTH=2: 5 illegal codes -> err_count 1,2,3,3,3; err_clear with an
//    illegal accept same cycle -> err_count=0.
// 5. Reset with buffer FULL and err_count=3 -> next cycle out_valid=0, in_ready=1,
//    err_count=0, binary_out=0; following accept 0010 -> binary_out 1.

Source files
------------

// File: rtl/one_hot_decoder.sv
// One-hot to binary index decoder with a 2-entry valid/ready skid buffer.
// Illegal codes (zero-hot or multi-hot) decode to the lowest set bit (or 0)
// and are flagged per entry and counted in a saturating counter.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no entries held, out_valid=0
// ST_ONE   | head entry valid, tail free
// ST_FULL  | head and tail valid, in_ready=0
module one_hot_decoder #(
  parameter int INPUT_WIDTH   = 4,
  parameter int OUTPUT_WIDTH  = $clog2(INPUT_WIDTH),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_WIDTH-1:0]   one_hot_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUTPUT_WIDTH-1:0]  binary_out,
  output logic                     out_err,
  input  logic                     err_clear,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [OUTPUT_WIDTH-1:0] dec_idx;
  logic                    dec_err;
  logic [OUTPUT_WIDTH-1:0] head_idx;
  logic                    head_err;
  logic [OUTPUT_WIDTH-1:0] tail_idx;
  logic                    tail_err;
  logic                    head_load;
  logic                    head_from_tail;
  logic                    tail_load;
  logic                    accept;
  logic                    emit;

  assign out_valid  = (state != ST_EMPTY);
  assign binary_out = head_idx;
  assign out_err    = head_err;
  assign accept     = in_valid & in_ready;
  assign emit       = out_valid & out_ready;

  // Decode: scan from the top so the lowest set bit wins on multi-hot codes.
  always_comb begin
    dec_idx = '0;
    for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
      if (one_hot_in[i]) dec_idx = OUTPUT_WIDTH'(i);
    end
    dec_err = (one_hot_in == '0) ||
              ((one_hot_in & (one_hot_in - INPUT_WIDTH'(1))) != '0);
  end

  // Buffer FSM next state and entry load controls.
  always_comb begin
    state_nxt      = state;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          head_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !emit) begin
          state_nxt = ST_FULL;
          tail_load = 1'b1;
        end else if (emit && !accept) begin
          state_nxt = ST_EMPTY;
        end else if (emit && accept) begin
          head_load = 1'b1;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_nxt      = ST_ONE;
          head_load      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State register and registered in_ready, derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  // Entry storage; the head holds its value after the buffer drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_idx <= '0;
      head_err <= 1'b0;
      tail_idx <= '0;
      tail_err <= 1'b0;
    end else begin
      if (head_load) begin
        head_idx <= head_from_tail ? tail_idx : dec_idx;
        head_err <= head_from_tail ? tail_err : dec_err;
      end
      if (tail_load) begin
        tail_idx <= dec_idx;
        tail_err <= dec_err;
      end
    end
  end

  // Saturating illegal-code counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if (accept && dec_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_one_hot_decoder.sv
// Directed bench for one_hot_decoder (INPUT_WIDTH=4, ERR_CNT_WIDTH=2).
// Inputs change and outputs are checked on the falling edge.
module tb_one_hot_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] one_hot_in;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] binary_out;
  logic       out_err;
  logic       err_clear;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;

  one_hot_decoder #(
    .INPUT_WIDTH  (4),
    .ERR_CNT_WIDTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .one_hot_in(one_hot_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binary_out(binary_out),
    .out_err   (out_err),
    .err_clear (err_clear),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check the full output set for one cycle.
  task automatic chk_out(input string tag, input logic v, input logic [1:0] b,
                         input logic e, input logic r, input logic [1:0] c);
    chk({tag, ".out_valid"},  {7'd0, out_valid},  {7'd0, v});
    chk({tag, ".binary_out"}, {6'd0, binary_out}, {6'd0, b});
    chk({tag, ".out_err"},    {7'd0, out_err},    {7'd0, e});
    chk({tag, ".in_ready"},   {7'd0, in_ready},   {7'd0, r});
    chk({tag, ".err_count"},  {6'd0, err_count},  {6'd0, c});
  endtask

  initial begin
    // Reset, with an illegal code presented to show reset has priority.
    rst_n = 1'b0; in_valid = 1'b1; one_hot_in = 4'b0000;
    out_ready = 1'b1; err_clear = 1'b0;
    cyc(); cyc();
    chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b1, 2'd0);
    rst_n = 1'b1; in_valid = 1'b0;

    // 1: legal codes back-to-back, out_ready=1.
    cyc();
    in_valid = 1'b1; one_hot_in = 4'b0001;
    cyc(); chk_out("t1.0", 1'b1, 2'd0, 1'b0, 1'b1, 2'd0);
    one_hot_in = 4'b0010;
    cyc(); chk_out("t1.1", 1'b1, 2'd1, 1'b0, 1'b1, 2'd0);
    one_hot_in = 4'b0100;
    cyc(); chk_out("t1.2", 1'b1, 2'd2, 1'b0, 1'b1, 2'd0);
    one_hot_in = 4'b1000;
    cyc(); chk_out("t1.3", 1'b1, 2'd3, 1'b0, 1'b1, 2'd0);
    in_valid = 1'b0;
    cyc(); chk_out("t1.drain", 1'b0, 2'd3, 1'b0, 1'b1, 2'd0);

    // 2: zero-hot then multi-hot.
    in_valid = 1'b1; one_hot_in = 4'b0000;
    cyc(); chk_out("t2.zero", 1'b1, 2'd0, 1'b1, 1'b1, 2'd1);
    one_hot_in = 4'b1010;
    cyc(); chk_out("t2.multi", 1'b1, 2'd1, 1'b1, 1'b1, 2'd2);
    in_valid = 1'b0;
    cyc(); chk_out("t2.drain", 1'b0, 2'd1, 1'b1, 1'b1, 2'd2);

    // 3: backpressure fills the skid buffer, then drains in order.
    out_ready = 1'b0; in_valid = 1'b1; one_hot_in = 4'b0100;
    cyc(); chk_out("t3.acc1", 1'b1, 2'd2, 1'b0, 1'b1, 2'd2);
    one_hot_in = 4'b1000;
    cyc(); chk_out("t3.full", 1'b1, 2'd2, 1'b0, 1'b0, 2'd2);
    one_hot_in = 4'b0001;
    cyc(); chk_out("t3.hold", 1'b1, 2'd2, 1'b0, 1'b0, 2'd2);
    out_ready = 1'b1;
    cyc(); chk_out("t3.em2", 1'b1, 2'd3, 1'b0, 1'b1, 2'd2);
    cyc(); chk_out("t3.em3", 1'b1, 2'd0, 1'b0, 1'b1, 2'd2);
    in_valid = 1'b0;
    cyc(); chk_out("t3.drain", 1'b0, 2'd0, 1'b0, 1'b1, 2'd2);

    // 4: saturation of a 2-bit counter, then clear beats increment.
    err_clear = 1'b1;
    cyc(); chk("t4.clr0", {6'd0, err_count}, 8'd0);
    err_clear = 1'b0; in_valid = 1'b1; one_hot_in = 4'b0000;
    cyc(); chk_out("t4.c1", 1'b1, 2'd0, 1'b1, 1'b1, 2'd1);
    one_hot_in = 4'b0011;
    cyc(); chk_out("t4.c2", 1'b1, 2'd0, 1'b1, 1'b1, 2'd2);
    one_hot_in = 4'b1111;
    cyc(); chk_out("t4.c3", 1'b1, 2'd0, 1'b1, 1'b1, 2'd3);
    one_hot_in = 4'b0110;
    cyc(); chk_out("t4.sat1", 1'b1, 2'd1, 1'b1, 1'b1, 2'd3);
    one_hot_in = 4'b1100;
    cyc(); chk_out("t4.sat2", 1'b1, 2'd2, 1'b1, 1'b1, 2'd3);
    one_hot_in = 4'b0101; err_clear = 1'b1;
    cyc(); chk_out("t4.clr", 1'b1, 2'd0, 1'b1, 1'b1, 2'd0);
    err_clear = 1'b0; in_valid = 1'b0;
    cyc(); chk_out("t4.drain", 1'b0, 2'd0, 1'b1, 1'b1, 2'd0);

    // 5: reset while FULL with err_count=3.
    in_valid = 1'b1; one_hot_in = 4'b0000; out_ready = 1'b1;
    cyc(); cyc();
    chk("t5.cnt2", {6'd0, err_count}, 8'd2);
    out_ready = 1'b0;
    cyc(); chk_out("t5.full", 1'b1, 2'd0, 1'b1, 1'b0, 2'd3);
    rst_n = 1'b0;
    cyc(); chk_out("t5.rst", 1'b0, 2'd0, 1'b0, 1'b1, 2'd0);
    rst_n = 1'b1; in_valid = 1'b1; one_hot_in = 4'b0010; out_ready = 1'b1;
    cyc(); chk_out("t5.post", 1'b1, 2'd1, 1'b0, 1'b1, 2'd0);
    in_valid = 1'b0;
    cyc(); chk_out("t5.drain", 1'b0, 2'd1, 1'b0, 1'b1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
